// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite motion block: FSM states,
// register map and the default travel limits of the sprite origin.
package sprite_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStepX,
    StStepY,
    StCommit
  } state_e;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_POS_X  = 3'd1;
  localparam logic [2:0] ADDR_POS_Y  = 3'd2;
  localparam logic [2:0] ADDR_VEL_X  = 3'd3;
  localparam logic [2:0] ADDR_VEL_Y  = 3'd4;
  localparam logic [2:0] ADDR_BOUNCE = 3'd5;

  localparam int DEF_SCREEN_W = 800;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_SPRITE_W = 64;
  localparam int DEF_SPRITE_H = 64;
  localparam int MAX_X = DEF_SCREEN_W - DEF_SPRITE_W;
  localparam int MAX_Y = DEF_SCREEN_H - DEF_SPRITE_H;

  // Clamp a signed register write into 0..lim.
  function automatic logic [15:0] clamp_pos(input logic [15:0] p, input logic [15:0] lim);
    if (p[15]) begin
      return 16'd0;
    end else if (p > lim) begin
      return lim;
    end else begin
      return p;
    end
  endfunction

  // -128 has no positive mirror in 8 bits, so it is pulled in to -127.
  function automatic logic [7:0] sat_vel(input logic [7:0] v);
    return (v == 8'h80) ? 8'h81 : v;
  endfunction

endpackage

// File: rtl/axis_reflect.sv
// One axis of sprite motion: advance pos by vel and mirror it back inside
// 0..limit, flipping the velocity when an edge is crossed.
module axis_reflect (
  input  logic [15:0] pos,
  input  logic [7:0]  vel,
  input  logic [15:0] limit,
  output logic [15:0] new_pos,
  output logic [7:0]  new_vel,
  output logic        bounced
);

  logic [16:0] nx;
  logic [16:0] refl;
  logic [16:0] lim17;

  always_comb begin
    lim17   = {1'b0, limit};
    nx      = {pos[15], pos} + {{9{vel[7]}}, vel};
    refl    = 17'd0;
    new_pos = nx[15:0];
    new_vel = vel;
    bounced = 1'b0;
    if (nx[16]) begin
      refl    = 17'd0 - nx;
      new_pos = refl[15:0];
      new_vel = 8'd0 - vel;
      bounced = 1'b1;
    end else if (nx > lim17) begin
      // Mirror about the limit: limit - (nx - limit).
      refl    = {lim17[15:0], 1'b0} - nx;
      new_pos = refl[15:0];
      new_vel = 8'd0 - vel;
      bounced = 1'b1;
    end
  end

endmodule

// File: rtl/sprite_motion.sv
// Per-frame sprite origin generator with edge reflection and an MCU register
// port; outputs only move in the short sequence following each frame tick.
module sprite_motion
  import sprite_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int SPRITE_W = DEF_SPRITE_W,
  parameter int SPRITE_H = DEF_SPRITE_H,
  parameter int INIT_X   = 0,
  parameter int INIT_Y   = 0,
  parameter int INIT_VX  = 1,
  parameter int INIT_VY  = 1
) (
  input  logic        clk_pix,
  input  logic        reset,
  input  logic        frame_int,
  input  logic        wr_en,
  input  logic [2:0]  addr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic [15:0] offset_x,
  output logic [15:0] offset_y,
  output logic        bounce_int,
  output logic [15:0] bounce_count
);

  localparam logic [15:0] LimX = 16'(SCREEN_W - SPRITE_W);
  localparam logic [15:0] LimY = 16'(SCREEN_H - SPRITE_H);

  state_e state_q, state_d;

  logic        frame_q;
  logic        tick;
  logic [15:0] x_q, y_q;
  logic [7:0]  vx_q, vy_q;
  logic        enable_q, overrun_q;
  logic [15:0] px_sh_q, py_sh_q;
  logic [7:0]  vx_sh_q, vy_sh_q;
  logic        pend_px_q, pend_py_q, pend_vx_q, pend_vy_q;
  logic        bx_q, by_q;
  logic [15:0] offset_x_q, offset_y_q, bounce_count_q, rd_data_q;
  logic        bounce_int_q;
  logic [15:0] rd_d;

  logic        wr_ctrl, wr_px, wr_py, wr_vx, wr_vy;
  logic [15:0] ax_pos, ay_pos;
  logic [7:0]  ax_vel, ay_vel;
  logic        ax_bounce, ay_bounce;

  assign tick    = frame_int & ~frame_q;
  assign wr_ctrl = wr_en && (addr == ADDR_CTRL);
  assign wr_px   = wr_en && (addr == ADDR_POS_X);
  assign wr_py   = wr_en && (addr == ADDR_POS_Y);
  assign wr_vx   = wr_en && (addr == ADDR_VEL_X);
  assign wr_vy   = wr_en && (addr == ADDR_VEL_Y);

  axis_reflect u_axis_x (
    .pos     (x_q),
    .vel     (vx_q),
    .limit   (LimX),
    .new_pos (ax_pos),
    .new_vel (ax_vel),
    .bounced (ax_bounce)
  );

  axis_reflect u_axis_y (
    .pos     (y_q),
    .vel     (vy_q),
    .limit   (LimY),
    .new_pos (ay_pos),
    .new_vel (ay_vel),
    .bounced (ay_bounce)
  );

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (tick) state_d = StLoad;
      StLoad:   state_d = StStepX;
      StStepX:  state_d = StStepY;
      StStepY:  state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Reads show a pending shadow value until it is loaded.
  always_comb begin
    rd_d = 16'd0;
    case (addr)
      ADDR_CTRL:   rd_d = {14'd0, overrun_q, enable_q};
      ADDR_POS_X:  rd_d = pend_px_q ? px_sh_q : x_q;
      ADDR_POS_Y:  rd_d = pend_py_q ? py_sh_q : y_q;
      ADDR_VEL_X:  rd_d = pend_vx_q ? {{8{vx_sh_q[7]}}, vx_sh_q} : {{8{vx_q[7]}}, vx_q};
      ADDR_VEL_Y:  rd_d = pend_vy_q ? {{8{vy_sh_q[7]}}, vy_sh_q} : {{8{vy_q[7]}}, vy_q};
      ADDR_BOUNCE: rd_d = bounce_count_q;
      default:     rd_d = 16'd0;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      frame_q        <= 1'b0;
      x_q            <= 16'(INIT_X);
      y_q            <= 16'(INIT_Y);
      vx_q           <= 8'(INIT_VX);
      vy_q           <= 8'(INIT_VY);
      enable_q       <= 1'b1;
      overrun_q      <= 1'b0;
      px_sh_q        <= 16'd0;
      py_sh_q        <= 16'd0;
      vx_sh_q        <= 8'd0;
      vy_sh_q        <= 8'd0;
      pend_px_q      <= 1'b0;
      pend_py_q      <= 1'b0;
      pend_vx_q      <= 1'b0;
      pend_vy_q      <= 1'b0;
      bx_q           <= 1'b0;
      by_q           <= 1'b0;
      offset_x_q     <= 16'(INIT_X);
      offset_y_q     <= 16'(INIT_Y);
      bounce_int_q   <= 1'b0;
      bounce_count_q <= 16'd0;
      rd_data_q      <= 16'd0;
    end else begin
      frame_q      <= frame_int;
      bounce_int_q <= 1'b0;
      rd_data_q    <= rd_d;

      if (wr_ctrl) begin
        enable_q <= wr_data[0];
        if (wr_data[1]) overrun_q <= 1'b0;
      end
      if (tick && (state_q != StIdle)) overrun_q <= 1'b1;

      if (wr_px) begin px_sh_q <= wr_data;          pend_px_q <= 1'b1; end
      if (wr_py) begin py_sh_q <= wr_data;          pend_py_q <= 1'b1; end
      if (wr_vx) begin vx_sh_q <= sat_vel(wr_data[7:0]); pend_vx_q <= 1'b1; end
      if (wr_vy) begin vy_sh_q <= sat_vel(wr_data[7:0]); pend_vy_q <= 1'b1; end

      case (state_q)
        StLoad: begin
          // A write landing this cycle keeps its flag and waits a frame.
          if (pend_px_q && !wr_px) begin x_q <= clamp_pos(px_sh_q, LimX); pend_px_q <= 1'b0; end
          if (pend_py_q && !wr_py) begin y_q <= clamp_pos(py_sh_q, LimY); pend_py_q <= 1'b0; end
          if (pend_vx_q && !wr_vx) begin vx_q <= vx_sh_q; pend_vx_q <= 1'b0; end
          if (pend_vy_q && !wr_vy) begin vy_q <= vy_sh_q; pend_vy_q <= 1'b0; end
          bx_q <= 1'b0;
          by_q <= 1'b0;
        end
        StStepX: begin
          if (enable_q) begin
            x_q  <= ax_pos;
            vx_q <= ax_vel;
            bx_q <= ax_bounce;
          end
        end
        StStepY: begin
          if (enable_q) begin
            y_q  <= ay_pos;
            vy_q <= ay_vel;
            by_q <= ay_bounce;
          end
        end
        StCommit: begin
          offset_x_q     <= x_q;
          offset_y_q     <= y_q;
          bounce_int_q   <= bx_q | by_q;
          bounce_count_q <= bounce_count_q + {15'd0, bx_q} + {15'd0, by_q};
        end
        default: ;
      endcase
    end
  end

  assign rd_data      = rd_data_q;
  assign offset_x     = offset_x_q;
  assign offset_y     = offset_y_q;
  assign bounce_int   = bounce_int_q;
  assign bounce_count = bounce_count_q;

endmodule
